multi_cycle_controller: RTL
===========================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port mem_ready, input, 1 bit: shared instruction/data memory completed the current access this cycle.
REQ-004 SHALL have port zero, input, 1 bit: ALU result equals 0.
REQ-005 SHALL have port sign, input, 1 bit: ALU result bit 31.
REQ-006 SHALL have ports opcode (7 bits), func3 (3 bits) and func7 (7 bits), all inputs, taken from the instruction register.
REQ-007 SHALL have output PCWrite, 1 bit: PC register load enable.
REQ-008 SHALL have output AdrSrc, 1 bit: memory address select; 0 = PC, 1 = Result.
REQ-009 SHALL have output IRWrite, 1 bit: loads the instruction register and OldPC.
REQ-010 SHALL have output MemWrite, 1 bit: memory write strobe.
REQ-011 SHALL have output RegWrite, 1 bit: register file write enable.
REQ-012 SHALL have output ResultSrc, 2 bits: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt.
REQ-013 SHALL have output ALUSrcA, 2 bits: 00 = PC, 01 = OldPC, 10 = rs1 data.
REQ-014 SHALL have output ALUSrcB, 2 bits: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
REQ-015 SHALL have output ALUControl, 3 bits, with these encodings:
- 000 = and
- 001 = or
- 010 = add
- 011 = xor
- 100 = sltu
- 110 = sub
- 111 = slt
REQ-016 SHALL have output ImmSrc, 3 bits: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-017 SHALL have output illegal, 1 bit: one-cycle pulse when an unsupported instruction is decoded.
REQ-018 SHALL have output instr_done, 1 bit: one-cycle pulse in the final state of each instruction.

Function
REQ-019 SHALL implement these FSM states: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR_ADDR, JALR, LUI_WB.
REQ-020 SHALL drive every output to 0 in any state that does not explicitly assign it; all outputs SHALL be Moore outputs except PCWrite in BRANCH and the mem_ready-qualified strobes.
REQ-021 In FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10; IRWrite and PCWrite SHALL equal mem_ready; the FSM SHALL hold in FETCH while mem_ready=0.
REQ-022 In DECODE: ALUSrcA=01, ALUSrcB=01, ALUControl=add (branch/jal target into ALUOut); ImmSrc SHALL be set per opcode.
REQ-023 From DECODE the FSM SHALL branch on opcode:
- lw 0000011 or sw 0100011 -> MEM_ADDR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR_ADDR
- 0110111 -> LUI_WB
- otherwise -> FETCH with illegal=1 for one cycle
REQ-024 Supported R-type operations SHALL be add, sub, sltu, slt, or, and; supported I-type operations SHALL be addi, sltiu, slti, xori, ori; branches SHALL be beq, bne, blt, bge. Any other func3/func7 combination SHALL be handled as illegal in DECODE.
REQ-025 MEM_ADDR SHALL drive ALUSrcA=10, ALUSrcB=01, add, ImmSrc I for lw and S for sw, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-026 MEM_READ SHALL drive AdrSrc=1, ResultSrc=00, and hold until mem_ready=1, then go to MEM_WB.
REQ-027 MEM_WB SHALL drive ResultSrc=01, RegWrite=1, instr_done=1, then go to FETCH.
REQ-028 MEM_WRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1, with instr_done=mem_ready; it SHALL then go to FETCH.
REQ-029 EXEC_R SHALL drive ALUSrcA=10, ALUSrcB=00; EXEC_I SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc I; both SHALL set ALUControl from func3/func7 and go to ALU_WB.
REQ-030 ALU_WB SHALL drive ResultSrc=00, RegWrite=1, instr_done=1, then go to FETCH.
REQ-031 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, instr_done=1, with PCWrite equal to the taken condition, then go to FETCH. Taken conditions:
- beq: zero
- bne: !zero
- blt: sign
- bge: !sign
REQ-032 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then go to ALU_WB (rd = OldPC+4).
REQ-033 JALR_ADDR SHALL drive ALUSrcA=10, ALUSrcB=01, add, ImmSrc I, then go to JALR; JALR SHALL drive the same controls as JAL, then go to ALU_WB.
REQ-034 LUI_WB SHALL drive ImmSrc=100, ResultSrc=11, RegWrite=1, instr_done=1, then go to FETCH.
REQ-035 With zero wait states, cycle counts SHALL be:
- lw: 5
- sw: 4
- R/I-type: 4
- branch: 3
- lui: 3
- jal: 4
- jalr: 5
Each wait cycle SHALL add exactly 1.

Reset
REQ-036 When rst=0 at a rising edge, the FSM SHALL enter FETCH and all outputs SHALL be 0 from the next cycle, regardless of the current state, including mid-MEM_WRITE.
REQ-037 After rst returns to 1, the first fetch SHALL begin in that cycle.

Structure
REQ-038 State encoding, opcode constants, and the ALUControl/ImmSrc/ResultSrc/ALUSrc encodings SHALL reside in a shared package, alongside the single-cycle controller's encodings.
REQ-039 An alu_decoder sub-module (opcode, func3, func7 -> ALUControl, legal) SHALL be instantiated.

Verification
REQ-040 Scenario: add with mem_ready=1 -> FETCH, DECODE, EXEC_R (ALUControl=010), ALU_WB (RegWrite=1, instr_done=1); 4 cycles total.
REQ-041 Scenario: lw with mem_ready low for 2 cycles in MEM_READ -> 7 cycles total; RegWrite=1 only in MEM_WB, with ResultSrc=01.
REQ-042 Scenario: beq with zero=1, then zero=0 -> PCWrite=1 in BRANCH only in the taken case; ALUControl=110 in both.
REQ-043 Scenario: jal -> JAL asserts PCWrite=1 with ALUSrcA=01, ALUSrcB=10; next cycle RegWrite=1 with ResultSrc=00.
REQ-044 Scenario: opcode 0000000 -> illegal=1 for one cycle in DECODE; no RegWrite or MemWrite; next state FETCH.
REQ-045 Scenario: rst=0 while in MEM_WRITE with MemWrite=1 -> MemWrite=0 the following cycle, state FETCH.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the RISC-V controllers.
// Holds the multi-cycle FSM state type, opcode constants, datapath mux and ALU encodings,
// the single-cycle controller's encodings, and a branch-condition helper.
package multi_cycle_controller_pkg;

  // Multi-cycle FSM states
  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalrAddr,
    StJalr,
    StLuiWb
  } mc_state_e;

  // Opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  // ALUControl
  localparam logic [2:0] AluAnd  = 3'b000;
  localparam logic [2:0] AluOr   = 3'b001;
  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluXor  = 3'b011;
  localparam logic [2:0] AluSltu = 3'b100;
  localparam logic [2:0] AluSub  = 3'b110;
  localparam logic [2:0] AluSlt  = 3'b111;

  // ImmSrc
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // ResultSrc
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResImmExt    = 2'b11;

  // ALUSrcA / ALUSrcB
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcBRs2   = 2'b00;
  localparam logic [1:0] SrcBImm   = 2'b01;
  localparam logic [1:0] SrcBFour  = 2'b10;

  // Single-cycle controller encodings (ALUOp to its ALU decoder, ResultSrc)
  localparam logic [1:0] ScAluOpAdd   = 2'b00;
  localparam logic [1:0] ScAluOpSub   = 2'b01;
  localparam logic [1:0] ScAluOpFunc  = 2'b10;
  localparam logic [1:0] ScResultAlu  = 2'b00;
  localparam logic [1:0] ScResultMem  = 2'b01;
  localparam logic [1:0] ScResultPc4  = 2'b10;

  // Branch taken condition from func3 and the flags of rs1 - rs2
  function automatic logic branch_taken(input logic [2:0] func3, input logic zero,
                                        input logic sign);
    logic taken;
    taken = 1'b0;
    case (func3)
      3'b000:  taken = zero;   // beq
      3'b001:  taken = !zero;  // bne
      3'b100:  taken = sign;   // blt
      3'b101:  taken = !sign;  // bge
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle.
// master: controller side (status/instruction fields in, control strobes out).
// slave:  datapath side (mirror image).
interface multi_cycle_controller_if;
  logic       mem_ready;
  logic       zero;
  logic       sign;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;

  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       illegal;
  logic       instr_done;

  modport master (
    input  mem_ready, zero, sign, opcode, func3, func7,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, illegal, instr_done
  );

  modport slave (
    output mem_ready, zero, sign, opcode, func3, func7,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, illegal, instr_done
  );
endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU decoder: maps opcode/func3/func7 to ALUControl and flags unsupported encodings.
// Ports: i_opcode, i_func3, i_func7 in; o_alu_control, o_legal out.
// Opcodes other than R/I/branch get add and are reported legal; opcode legality is the FSM's job.
module multi_cycle_controller_alu_decoder
  import multi_cycle_controller_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  output logic [2:0] o_alu_control,
  output logic       o_legal
);

  always_comb begin
    o_alu_control = AluAdd;
    o_legal       = 1'b1;
    case (i_opcode)
      OpR: begin
        if (i_func7 == 7'b0000000) begin
          case (i_func3)
            3'b000:  o_alu_control = AluAdd;
            3'b010:  o_alu_control = AluSlt;
            3'b011:  o_alu_control = AluSltu;
            3'b110:  o_alu_control = AluOr;
            3'b111:  o_alu_control = AluAnd;
            default: o_legal = 1'b0;
          endcase
        end else if (i_func7 == 7'b0100000 && i_func3 == 3'b000) begin
          o_alu_control = AluSub;
        end else begin
          o_legal = 1'b0;
        end
      end
      OpI: begin
        // andi and shifts are not supported
        case (i_func3)
          3'b000:  o_alu_control = AluAdd;
          3'b010:  o_alu_control = AluSlt;
          3'b011:  o_alu_control = AluSltu;
          3'b100:  o_alu_control = AluXor;
          3'b110:  o_alu_control = AluOr;
          default: o_legal = 1'b0;
        endcase
      end
      OpBranch: begin
        o_alu_control = AluSub;
        case (i_func3)
          3'b000, 3'b001, 3'b100, 3'b101: o_legal = 1'b1;
          default:                        o_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32 subset controller (Moore FSM).
// Ports: clk, rst (synchronous, active-low); bus (master modport) carrying mem_ready, zero,
// sign, opcode, func3, func7 in and PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
// ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instr_done out.
// All outputs are forced to 0 while rst is low; the fetch starts as soon as rst is released.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  multi_cycle_controller_if.master       bus
);

  mc_state_e  r_state;
  mc_state_e  w_state_next;

  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [2:0] w_alu_control;
  logic [2:0] w_imm_src;
  logic       w_illegal;
  logic       w_instr_done;

  logic [2:0] w_dec_alu_control;
  logic       w_dec_legal;

  multi_cycle_controller_alu_decoder u_alu_decoder (
    .i_opcode      (bus.opcode),
    .i_func3       (bus.func3),
    .i_func7       (bus.func7),
    .o_alu_control (w_dec_alu_control),
    .o_legal       (w_dec_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_write    = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_alu_control = 3'b000;
    w_imm_src     = 3'b000;
    w_illegal     = 1'b0;
    w_instr_done  = 1'b0;

    unique case (r_state)
      StFetch: begin
        w_adr_src     = 1'b0;
        w_alu_src_a   = SrcAPc;
        w_alu_src_b   = SrcBFour;
        w_alu_control = AluAdd;
        w_result_src  = ResAluResult;
        w_ir_write    = bus.mem_ready;
        w_pc_write    = bus.mem_ready;
        if (bus.mem_ready) w_state_next = StDecode;
      end
      StDecode: begin
        // Precompute the branch/jal target into ALUOut
        w_alu_src_a   = SrcAOldPc;
        w_alu_src_b   = SrcBImm;
        w_alu_control = AluAdd;
        case (bus.opcode)
          OpLoad, OpStore: w_state_next = StMemAddr;
          OpR:             w_state_next = StExecR;
          OpI:             w_state_next = StExecI;
          OpBranch:        w_state_next = StBranch;
          OpJal:           w_state_next = StJal;
          OpJalr:          w_state_next = StJalrAddr;
          OpLui:           w_state_next = StLuiWb;
          default: begin
            w_illegal    = 1'b1;
            w_state_next = StFetch;
          end
        endcase
        case (bus.opcode)
          OpStore:  w_imm_src = ImmS;
          OpBranch: w_imm_src = ImmB;
          OpJal:    w_imm_src = ImmJ;
          OpLui:    w_imm_src = ImmU;
          default:  w_imm_src = ImmI;
        endcase
        if (!w_dec_legal) begin
          w_illegal    = 1'b1;
          w_state_next = StFetch;
        end
      end
      StMemAddr: begin
        w_alu_src_a   = SrcARs1;
        w_alu_src_b   = SrcBImm;
        w_alu_control = AluAdd;
        if (bus.opcode == OpStore) begin
          w_imm_src    = ImmS;
          w_state_next = StMemWrite;
        end else begin
          w_imm_src    = ImmI;
          w_state_next = StMemRead;
        end
      end
      StMemRead: begin
        w_adr_src    = 1'b1;
        w_result_src = ResAluOut;
        if (bus.mem_ready) w_state_next = StMemWb;
      end
      StMemWb: begin
        w_result_src = ResData;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = StFetch;
      end
      StMemWrite: begin
        w_adr_src    = 1'b1;
        w_result_src = ResAluOut;
        w_mem_write  = 1'b1;
        w_instr_done = bus.mem_ready;
        if (bus.mem_ready) w_state_next = StFetch;
      end
      StExecR: begin
        w_alu_src_a   = SrcARs1;
        w_alu_src_b   = SrcBRs2;
        w_alu_control = w_dec_alu_control;
        w_state_next  = StAluWb;
      end
      StExecI: begin
        w_alu_src_a   = SrcARs1;
        w_alu_src_b   = SrcBImm;
        w_imm_src     = ImmI;
        w_alu_control = w_dec_alu_control;
        w_state_next  = StAluWb;
      end
      StAluWb: begin
        w_result_src = ResAluOut;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = StFetch;
      end
      StBranch: begin
        // ALUOut holds the target computed in DECODE; the ALU compares rs1 - rs2
        w_alu_src_a   = SrcARs1;
        w_alu_src_b   = SrcBRs2;
        w_alu_control = AluSub;
        w_result_src  = ResAluOut;
        w_instr_done  = 1'b1;
        w_pc_write    = branch_taken(bus.func3, bus.zero, bus.sign);
        w_state_next  = StFetch;
      end
      StJal, StJalr: begin
        // PC <- ALUOut (target) while the ALU forms OldPC + 4 for the link write
        w_alu_src_a   = SrcAOldPc;
        w_alu_src_b   = SrcBFour;
        w_alu_control = AluAdd;
        w_result_src  = ResAluOut;
        w_pc_write    = 1'b1;
        w_state_next  = StAluWb;
      end
      StJalrAddr: begin
        w_alu_src_a   = SrcARs1;
        w_alu_src_b   = SrcBImm;
        w_alu_control = AluAdd;
        w_imm_src     = ImmI;
        w_state_next  = StJalr;
      end
      StLuiWb: begin
        w_imm_src    = ImmU;
        w_result_src = ResImmExt;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = StFetch;
      end
      default: w_state_next = StFetch;
    endcase
  end

  assign bus.PCWrite    = rst & w_pc_write;
  assign bus.AdrSrc     = rst & w_adr_src;
  assign bus.IRWrite    = rst & w_ir_write;
  assign bus.MemWrite   = rst & w_mem_write;
  assign bus.RegWrite   = rst & w_reg_write;
  assign bus.ResultSrc  = rst ? w_result_src  : 2'b00;
  assign bus.ALUSrcA    = rst ? w_alu_src_a   : 2'b00;
  assign bus.ALUSrcB    = rst ? w_alu_src_b   : 2'b00;
  assign bus.ALUControl = rst ? w_alu_control : 3'b000;
  assign bus.ImmSrc     = rst ? w_imm_src     : 3'b000;
  assign bus.illegal    = rst & w_illegal;
  assign bus.instr_done = rst & w_instr_done;

endmodule
